// File: rtl/cpu_run_controller.sv
// Run/halt/single-step sequencer for the FPGA RISC-V core, with retired-instruction count and display register scan.
// Optional PC breakpoint (compare, skip flag, BREAK state) is built when RUNCTL_BREAKPOINT_EN is defined.
module cpu_run_controller #(
  parameter int unsigned PC_WIDTH          = 32,
  parameter int unsigned CNT_WIDTH         = 32,
  parameter int unsigned RESET_HOLD_CYCLES = 4,
  parameter int unsigned SCAN_DIV          = 25_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_run,
  input  logic                 btn_step,
  input  logic                 btn_halt,
  input  logic [4:0]           sw_sel,
  input  logic                 scan_mode,
  input  logic                 bp_en,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 core_reset,
  output logic                 core_en,
  output logic [4:0]           reg_sel,
  output logic [2:0]           state,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_HALT  = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [2:0]        btn_raw;
  logic [2:0]        sync1;
  logic [2:0]        sync2;
  logic [2:0]        btn_prev;
  logic [2:0]        btn_pulse;
  logic              run_p;
  logic              step_p;
  logic              halt_p;
  logic              bp_hit;

  assign state = state_q;

  // Button synchronizers and rising-edge detect (one pulse per press)
  assign btn_raw   = {btn_halt, btn_step, btn_run};
  assign btn_pulse = sync2 & ~btn_prev;
  assign run_p     = btn_pulse[0];
  assign step_p    = btn_pulse[1];
  assign halt_p    = btn_pulse[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      btn_prev <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      btn_prev <= sync2;
    end
  end

`ifdef RUNCTL_BREAKPOINT_EN
  // skip lets the first RUN cycle after a break execute the instruction at bp_addr
  logic skip_q;

  assign bp_hit = bp_en && (pc == bp_addr) && !skip_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skip_q <= 1'b0;
    end else if ((state_q == S_BREAK) && (state_d == S_RUN)) begin
      skip_q <= 1'b1;
    end else if (state_q == S_RUN) begin
      skip_q <= 1'b0;
    end
  end
`else
  logic unused_bp;

  assign unused_bp = ^{bp_en, bp_addr, pc};
  assign bp_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; pulse priority halt > step > run
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD: begin
        if (hold_cnt <= HOLD_W'(1)) state_d = S_HALT;
      end
      S_HALT, S_BREAK: begin
        if (!halt_p) begin
          if (step_p)     state_d = S_STEP;
          else if (run_p) state_d = S_RUN;
        end
      end
      S_STEP: state_d = S_HALT;
      S_RUN: begin
        if (halt_p)      state_d = S_HALT;
        else if (bp_hit) state_d = S_BREAK;
      end
      default: state_d = S_HOLD;
    endcase
  end

  // Core clock enable follows state and the breakpoint compare with no register delay
  always_comb begin
    core_en = 1'b0;
    case (state_q)
      S_STEP:  core_en = 1'b1;
      S_RUN:   core_en = !bp_hit;
      default: core_en = 1'b0;
    endcase
  end

  // Registered state decodes, aligned with the state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_reset <= 1'b1;
      halted     <= 1'b0;
    end else begin
      core_reset <= (state_d == S_HOLD);
      halted     <= (state_d == S_HALT) || (state_d == S_BREAK);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= HOLD_W'(RESET_HOLD_CYCLES);
    end else if ((state_q == S_HOLD) && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count <= '0;
    end else if (core_en) begin
      instr_count <= instr_count + CNT_WIDTH'(1);
    end
  end

  // Display register select: follow switches, or step through all 32 every SCAN_DIV cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_sel <= '0;
      div_cnt <= '0;
    end else if (!scan_mode) begin
      reg_sel <= sw_sel;
      div_cnt <= '0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      reg_sel <= reg_sel + 5'd1;
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule
